// File: rtl/ras_spec_stack_pkg.sv
// Shared types and width helpers for the return-address stack.
// ras_t / ras_ckpt_t are declared at the default widths for consumers
// elsewhere in the frontend. The stack itself rebuilds the same layouts
// locally from its own parameters.
package ras_spec_stack_pkg;

  localparam int unsigned RasVlen  = 32;
  localparam int unsigned RasDepth = 4;

  // Pointer width for a DEPTH-entry circular buffer (never below 1 bit)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must hold 0..DEPTH inclusive
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned PtrW = ptr_w(RasDepth);
  localparam int unsigned CntW = cnt_w(RasDepth);

  typedef struct packed {
    logic               valid;
    logic [RasVlen-1:0] ra;
  } ras_t;

  typedef struct packed {
    logic [PtrW-1:0]    tos;
    logic [CntW-1:0]    count;
    logic [RasVlen-1:0] top_ra;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_table.sv
// Checkpoint slot array for speculative RAS state.
// One write port (save) and one combinational read port (restore). A save
// and a read of the same slot in one cycle returns the old contents.
module ras_ckpt_table #(
  parameter int unsigned NR_CKPT = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned IdW     = $clog2(NR_CKPT)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           save_i,
  input  logic [IdW-1:0] save_id_i,
  input  logic [W-1:0]   save_data_i,
  input  logic [IdW-1:0] rd_id_i,
  output logic [W-1:0]   rd_data_o
);

  logic [NR_CKPT-1:0][W-1:0] slots;

  // Slot storage: cleared on reset, one slot written per save
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     slots <= '0;
    else if (save_i) slots[save_id_i] <= save_data_i;
  end

  assign rd_data_o = slots[rd_id_i];

endmodule

// File: rtl/ras_spec_stack.sv
// Parametrised return-address stack (circular, overflow drops oldest).
// Optional checkpoint/restore is built only when RAS_CKPT_EN is defined;
// otherwise the checkpoint ports exist but are ignored.
// data_o layout is {valid, ra}, identical to ras_t.
module ras_spec_stack
  import ras_spec_stack_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VLEN    = 32,
  parameter int unsigned NR_CKPT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  output logic [VLEN:0]              data_o,
  input  logic                       ckpt_save_i,
  input  logic [$clog2(NR_CKPT)-1:0] ckpt_id_i,
  input  logic                       ckpt_restore_i,
  input  logic [$clog2(NR_CKPT)-1:0] ckpt_rid_i
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  // Same field order as ras_ckpt_t, sized from this instance's parameters
  typedef struct packed {
    logic [PW-1:0]   tos;
    logic [CW-1:0]   count;
    logic [VLEN-1:0] top_ra;
  } ckpt_t;

  logic [DEPTH-1:0][VLEN-1:0] mem;
  logic [PW-1:0]   tos, tos_n, tos_inc, tos_dec;
  logic [CW-1:0]   cnt, cnt_n;
  logic            we;
  logic [PW-1:0]   waddr;
  logic [VLEN-1:0] wdata;
  logic            restore_en;
  ckpt_t           rd_slot;

  // Explicit wrap so non-power-of-two depths stay in range
  assign tos_inc = (tos == LastPtr) ? '0 : tos + 1'b1;
  assign tos_dec = (tos == '0) ? LastPtr : tos - 1'b1;

`ifdef RAS_CKPT_EN
  ckpt_t save_slot;

  // Snapshot is taken from current (pre-update) state
  assign save_slot  = '{tos: tos, count: cnt, top_ra: mem[tos]};
  assign restore_en = ckpt_restore_i;

  ras_ckpt_table #(
    .NR_CKPT (NR_CKPT),
    .W       ($bits(ckpt_t))
  ) u_ckpt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .save_i      (ckpt_save_i),
    .save_id_i   (ckpt_id_i),
    .save_data_i (save_slot),
    .rd_id_i     (ckpt_rid_i),
    .rd_data_o   (rd_slot)
  );
`else
  logic unused_ckpt;

  assign restore_en  = 1'b0;
  assign rd_slot     = '0;
  assign unused_ckpt = ^{ckpt_save_i, ckpt_id_i, ckpt_restore_i, ckpt_rid_i};
`endif

  // Next-state selection: flush > restore > push/pop
  always_comb begin
    tos_n = tos;
    cnt_n = cnt;
    we    = 1'b0;
    waddr = tos;
    wdata = data_i;
    if (flush_i) begin
      tos_n = '0;
      cnt_n = '0;
    end else if (restore_en) begin
      // Rewrite the saved top in case a later push clobbered it
      tos_n = rd_slot.tos;
      cnt_n = rd_slot.count;
      we    = 1'b1;
      waddr = rd_slot.tos;
      wdata = rd_slot.top_ra;
    end else if (push_i && pop_i) begin
      we    = 1'b1;
      if (cnt == '0) cnt_n = CW'(1);
    end else if (push_i) begin
      tos_n = tos_inc;
      we    = 1'b1;
      waddr = tos_inc;
      if (cnt != FullCnt) cnt_n = cnt + 1'b1;
    end else if (pop_i && (cnt != '0)) begin
      tos_n = tos_dec;
      cnt_n = cnt - 1'b1;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos <= '0;
      cnt <= '0;
    end else begin
      tos <= tos_n;
      cnt <= cnt_n;
    end
  end

  // Entry storage; flush leaves contents in place
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  mem <= '0;
    else if (we)  mem[waddr] <= wdata;
  end

  assign data_o = {(cnt != '0), mem[tos]};

endmodule

// File: tb/tb_ras_spec_stack.sv
// Self-checking bench for ras_spec_stack. A queue-based reference stack
// produces the expected top each cycle; expectations go into a scoreboard
// queue at drive time and are popped when the DUT output is sampled.
module tb_ras_spec_stack;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned VLEN    = 32;
  localparam int unsigned NR_CKPT = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i, push_i, pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN:0]   data_o;
  logic            ckpt_save_i, ckpt_restore_i;
  logic [1:0]      ckpt_id_i, ckpt_rid_i;

  int checks = 0;
  int errors = 0;

  logic [VLEN-1:0] mdl[$];
  logic [VLEN:0]   exp_q[$];

  ras_spec_stack #(.DEPTH(DEPTH), .VLEN(VLEN), .NR_CKPT(NR_CKPT)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .ckpt_save_i    (ckpt_save_i),
    .ckpt_id_i      (ckpt_id_i),
    .ckpt_restore_i (ckpt_restore_i),
    .ckpt_rid_i     (ckpt_rid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1);
  end

  // Drive one cycle of stimulus, advance the reference, queue the expectation
  task automatic drive(input logic f, input logic pu, input logic po, input logic [VLEN-1:0] d);
    flush_i = f; push_i = pu; pop_i = po; data_i = d;
    if (f) mdl.delete();
    else if (pu && po) begin
      if (mdl.size() == 0) mdl.push_back(d);
      else mdl[mdl.size()-1] = d;
    end else if (pu) begin
      mdl.push_back(d);
      if (mdl.size() > DEPTH) void'(mdl.pop_front());
    end else if (po) begin
      if (mdl.size() != 0) void'(mdl.pop_back());
    end
    if (mdl.size() != 0) exp_q.push_back({1'b1, mdl[mdl.size()-1]});
    else                 exp_q.push_back({1'b0, {VLEN{1'b0}}});
    @(posedge clk_i); #1;
    flush_i = 0; push_i = 0; pop_i = 0; ckpt_save_i = 0; ckpt_restore_i = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (data_o !== '0) begin
      errors++; $display("FAIL reset_hold: got %h want %h", data_o, {(VLEN+1){1'b0}});
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (data_o !== '0) begin
      errors++; $display("FAIL reset_release: got %h want %h", data_o, {(VLEN+1){1'b0}});
    end
  endtask

  task automatic test_push_pop();
    logic [2:0]      ops [7] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [VLEN-1:0] dat [7] = '{32'h100, 32'h200, 32'h300, 0, 0, 0, 0};
    logic [VLEN:0]   e;
    for (int i = 0; i < 7; i++) begin
      drive(ops[i][2], ops[i][1], ops[i][0], dat[i]);
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL push_pop step %0d: got %h want %h", i, data_o, e);
      end
      if (i == 2) begin
        checks++;
        if (data_o !== {1'b1, 32'h300}) begin
          errors++; $display("FAIL push_pop_top: got %h want %h", data_o, {1'b1, 32'h300});
        end
      end
      if (i == 6) begin
        checks++;
        if (data_o[VLEN] !== 1'b0) begin
          errors++; $display("FAIL underflow_valid: got %b want 0", data_o[VLEN]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [VLEN:0] e;
    logic [VLEN:0] want [5] = '{{1'b1, 32'h50}, {1'b1, 32'h40}, {1'b1, 32'h30}, {1'b1, 32'h20}, '0};
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, VLEN'((i + 1) * 16));
      e = exp_q.pop_front(); checks++;
      if (data_o !== e) begin
        errors++; $display("FAIL overflow_push %0d: got %h want %h", i, data_o, e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      // Top before this pop, then pop it
      checks++;
      if (data_o[VLEN] !== want[i][VLEN] || (want[i][VLEN] && data_o !== want[i])) begin
        errors++; $display("FAIL overflow_pop %0d: got %h want %h", i, data_o, want[i]);
      end
      drive(0, 0, 1, 0);
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL overflow_model %0d: got %h want %h", i, data_o, e);
      end
    end
  endtask

  task automatic test_push_and_pop();
    logic [2:0]      ops [3] = '{3'b010, 3'b011, 3'b001};
    logic [VLEN-1:0] dat [3] = '{32'hA0, 32'hB0, 0};
    logic [VLEN:0]   e;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i][2], ops[i][1], ops[i][0], dat[i]);
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL push_and_pop step %0d: got %h want %h", i, data_o, e);
      end
      if (i == 1) begin
        checks++;
        if (data_o !== {1'b1, 32'hB0}) begin
          errors++; $display("FAIL push_and_pop_top: got %h want %h", data_o, {1'b1, 32'hB0});
        end
      end
    end
    // count must have stayed 1: the single pop emptied it
    checks++;
    if (data_o[VLEN] !== 1'b0) begin
      errors++; $display("FAIL push_and_pop_count: valid %b want 0", data_o[VLEN]);
    end
  endtask

  task automatic test_flush();
    logic [2:0]      ops [4] = '{3'b010, 3'b010, 3'b110, 3'b010};
    logic [VLEN-1:0] dat [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    logic [VLEN:0]   e;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i][2], ops[i][1], ops[i][0], dat[i]);
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL flush step %0d: got %h want %h", i, data_o, e);
      end
      if (i == 2) begin
        checks++;
        if (data_o[VLEN] !== 1'b0) begin
          errors++; $display("FAIL flush_valid: got %b want 0", data_o[VLEN]);
        end
      end
    end
    checks++;
    if (data_o !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL flush_then_push: got %h want %h", data_o, {1'b1, 32'h4});
    end
  endtask

`ifdef RAS_CKPT_EN
  task automatic test_ckpt();
    logic [VLEN-1:0] saved[$];
    logic [VLEN:0]   e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, 1, 0, 32'h1);
        1: drive(0, 1, 0, 32'h2);
        2: begin ckpt_save_i = 1; ckpt_id_i = 2'd1; saved = mdl; drive(0, 0, 0, 0); end
        3: drive(0, 0, 1, 0);
        4: drive(0, 1, 0, 32'h9);
        default: begin ckpt_restore_i = 1; ckpt_rid_i = 2'd1; mdl = saved; drive(0, 0, 0, 0); end
      endcase
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL ckpt step %0d: got %h want %h", i, data_o, e);
      end
    end
    checks++;
    if (data_o !== {1'b1, 32'h2}) begin
      errors++; $display("FAIL ckpt_restore_top: got %h want %h", data_o, {1'b1, 32'h2});
    end
    drive(0, 0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (data_o !== {1'b1, 32'h1} || data_o !== e) begin
      errors++; $display("FAIL ckpt_restore_pop: got %h want %h", data_o, {1'b1, 32'h1});
    end
  endtask
`else
  task automatic test_ckpt();
    logic [VLEN:0] e;
    drive(0, 1, 0, 32'h77);
    void'(exp_q.pop_front());
    // Restore/save must have no effect in this build
    ckpt_save_i = 1; ckpt_id_i = 2'd0; ckpt_restore_i = 1; ckpt_rid_i = 2'd0;
    drive(0, 0, 0, 0);
    e = exp_q.pop_front(); checks++;
    if (data_o !== {1'b1, 32'h77} || data_o !== e) begin
      errors++; $display("FAIL ckpt_ignored: got %h want %h", data_o, {1'b1, 32'h77});
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [VLEN:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, VLEN'(32'hC00 + i));
      void'(exp_q.pop_front());
    end
    checks++;
    if (data_o !== {1'b1, 32'hC02}) begin
      errors++; $display("FAIL reset_mid_pre: got %h want %h", data_o, {1'b1, 32'hC02});
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (data_o !== '0) begin
      errors++; $display("FAIL reset_mid_async: got %h want %h", data_o, {(VLEN+1){1'b0}});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mdl.delete();
    drive(0, 0, 1, 0);
    e = exp_q.pop_front(); checks++;
    if (data_o[VLEN] !== 1'b0 || data_o[VLEN] !== e[VLEN]) begin
      errors++; $display("FAIL reset_mid_pop: valid %b want 0", data_o[VLEN]);
    end
  endtask

  task automatic test_back_to_back();
    logic [VLEN:0] e;
    int unsigned   r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if      (r == 0) drive(1, 0, 0, $urandom);
      else if (r < 9)  drive(0, 1, 0, $urandom);
      else if (r < 16) drive(0, 0, 1, 0);
      else             drive(0, 1, 1, $urandom);
      e = exp_q.pop_front(); checks++;
      if (data_o[VLEN] !== e[VLEN] || (e[VLEN] && data_o[VLEN-1:0] !== e[VLEN-1:0])) begin
        errors++; $display("FAIL back_to_back step %0d: got %h want %h", i, data_o, e);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 0; push_i = 0; pop_i = 0; data_i = '0;
    ckpt_save_i = 0; ckpt_restore_i = 0; ckpt_id_i = '0; ckpt_rid_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_push_pop();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_overflow();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_push_and_pop();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_flush();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_ckpt();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_reset_mid();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
